// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - control/serial-output bundle between a pattern source and seq_gen
interface seq_gen_if #(
  parameter int W  = 16,
  parameter int LW = 5
) ();
  logic          load;
  logic [W-1:0]  pat;
  logic [LW-1:0] len;
  logic          rep;
  logic          start;
  logic          stop;
  logic          tick;
  logic          bit_out;
  logic          bit_vld;
  logic          run4;
  logic          busy;
  logic          done;

  modport master (
    output load, pat, len, rep, start, stop, tick,
    input  bit_out, bit_vld, run4, busy, done
  );

  modport slave (
    input  load, pat, len, rep, start, stop, tick,
    output bit_out, bit_vld, run4, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - MSB-first serial pattern generator with run-of-four marking
module seq_gen #(
  parameter int W  = 16,
  parameter int LW = 5
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  seq_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0] W_LEN = LW'(W);

  state_t        state_q, state_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [LW-1:0] lenq_q, lenq_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [2:0]    run_q, run_d;
  logic          bit_out_q, bit_out_d;
  logic          bit_vld_q, bit_vld_d;
  logic          run4_q, run4_d;

  logic          accept_start;
  logic          emit;
  logic          last_bit;
  logic [W-1:0]  start_pat;
  logic [LW-1:0] len_clamped;
  logic [2:0]    run_next;

  // A zero-length start is dropped; a same-cycle load feeds the new pattern straight in.
  assign accept_start = (state_q == S_IDLE) && bus.start && (bus.len != '0);
  assign emit         = (state_q == S_SEND) && bus.tick && !bus.stop;
  assign last_bit     = (cnt_q == LW'(1));
  assign start_pat    = bus.load ? bus.pat : shadow_q;
  assign len_clamped  = (bus.len > W_LEN) ? W_LEN : bus.len;

  // Run length of the bit about to be emitted; run_q==0 marks the first bit of a send.
  always_comb begin
    run_next = 3'd1;
    if ((run_q != 3'd0) && (shift_q[W-1] == bit_out_q)) begin
      run_next = (run_q == 3'd4) ? 3'd4 : run_q + 3'd1;
    end
  end

  // Datapath next-state: shadow capture, send setup, per-tick shift and repeat wrap.
  always_comb begin
    shadow_d  = shadow_q;
    shift_d   = shift_q;
    lenq_d    = lenq_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    bit_out_d = bit_out_q;
    bit_vld_d = 1'b0;
    run4_d    = 1'b0;
    if ((state_q == S_IDLE) && bus.load) begin
      shadow_d = bus.pat;
    end
    if (accept_start) begin
      lenq_d  = len_clamped;
      shift_d = start_pat;
      cnt_d   = len_clamped;
      run_d   = 3'd0;
    end else if (emit) begin
      bit_out_d = shift_q[W-1];
      bit_vld_d = 1'b1;
      run_d     = run_next;
      run4_d    = (run_next == 3'd4);
      if (last_bit && bus.rep) begin
        shift_d = shadow_q;
        cnt_d   = lenq_q;
      end else begin
        shift_d = {shift_q[W-2:0], 1'b0};
        cnt_d   = cnt_q - LW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= '0;
      shift_q   <= '0;
      lenq_q    <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      bit_out_q <= 1'b0;
      bit_vld_q <= 1'b0;
      run4_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      shift_q   <= shift_d;
      lenq_q    <= lenq_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      bit_out_q <= bit_out_d;
      bit_vld_q <= bit_vld_d;
      run4_q    <= run4_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop beats a simultaneous tick; a non-repeating last bit ends in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_start) state_d = S_SEND;
      S_SEND: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (emit && last_bit && !bus.rep) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register, serial outputs straight from flops.
  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_DONE);
    bus.bit_out = bit_out_q;
    bus.bit_vld = bit_vld_q;
    bus.run4    = run4_q;
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - randomized self-checking bench for seq_gen against a queue model
module tb_seq_gen;
  localparam int W  = 16;
  localparam int LW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_gen_if #(.W(W), .LW(LW)) bus ();

  seq_gen #(.W(W), .LW(LW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining bits of the current pass in a queue, recent history for runs.
  typedef enum {M_IDLE, M_SEND, M_DONE} mphase_t;
  mphase_t      m_phase;
  logic [W-1:0] m_shadow;
  int           m_lenq;
  bit           m_bit, m_vld, m_run4;
  bit           m_q[$];
  bit           m_hist[$];

  int           obs_vld, obs_run4, obs_done;
  logic [31:0]  obs_word;

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_shadow = '0;
    m_lenq   = 0;
    m_bit    = 1'b0;
    m_vld    = 1'b0;
    m_run4   = 1'b0;
    m_q.delete();
    m_hist.delete();
  endtask

  task automatic load_pass();
    for (int i = 0; i < m_lenq; i++) m_q.push_back(m_shadow[W-1-i]);
  endtask

  task automatic model_edge();
    bit b;
    bit same;
    m_vld  = 1'b0;
    m_run4 = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      M_DONE: m_phase = M_IDLE;
      M_IDLE: begin
        if (bus.load) m_shadow = bus.pat;
        if (bus.start && bus.len != 0) begin
          m_lenq = (int'(bus.len) > W) ? W : int'(bus.len);
          m_q.delete();
          load_pass();
          m_hist.delete();
          m_phase = M_SEND;
        end
      end
      M_SEND: begin
        if (bus.stop) begin
          m_phase = M_IDLE;
        end else if (bus.tick) begin
          b = m_q.pop_front();
          m_bit = b;
          m_vld = 1'b1;
          m_hist.push_back(b);
          if (m_hist.size() > 4) void'(m_hist.pop_front());
          same = (m_hist.size() == 4);
          foreach (m_hist[i]) if (m_hist[i] != b) same = 1'b0;
          m_run4 = same;
          if (m_q.size() == 0) begin
            if (bus.rep) load_pass();
            else m_phase = M_DONE;
          end
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare_outputs();
    check_eq("bit_out", 32'(bus.bit_out), 32'(m_bit));
    check_eq("bit_vld", 32'(bus.bit_vld), 32'(m_vld));
    check_eq("run4",    32'(bus.run4),    32'(m_run4));
    check_eq("busy",    32'(bus.busy),    32'(m_phase != M_IDLE));
    check_eq("done",    32'(bus.done),    32'(m_phase == M_DONE));
    if (bus.bit_vld === 1'b1) begin
      obs_vld++;
      obs_word = {obs_word[30:0], bus.bit_out};
    end
    if (bus.run4 === 1'b1) obs_run4++;
    if (bus.done === 1'b1) obs_done++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic clear_inputs();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.tick  = 1'b0;
  endtask

  task automatic clr_obs();
    obs_vld  = 0;
    obs_run4 = 0;
    obs_done = 0;
    obs_word = '0;
  endtask

  task automatic do_load(input logic [W-1:0] p);
    bus.pat  = p;
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
  endtask

  task automatic do_start(input int l, input bit r);
    bus.len   = LW'(l);
    bus.rep   = r;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bit_out"}, 32'(bus.bit_out), 32'd0);
    check_eq({tag, "_bit_vld"}, 32'(bus.bit_vld), 32'd0);
    check_eq({tag, "_run4"},    32'(bus.run4),    32'd0);
    check_eq({tag, "_busy"},    32'(bus.busy),    32'd0);
    check_eq({tag, "_done"},    32'(bus.done),    32'd0);
  endtask

  initial begin
    clear_inputs();
    bus.pat = '0;
    bus.len = '0;
    bus.rep = 1'b0;
    model_reset();
    clr_obs();
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) cycle();
    #2 rst_n = 1'b1;
    repeat (2) cycle();

    // Basic send with runs.
    do_load(16'hF00F);
    clr_obs();
    bus.tick = 1'b1;
    do_start(16, 1'b0);
    repeat (20) cycle();
    bus.tick = 1'b0;
    check_eq("f00f_bits",  obs_word[15:0], 32'h0000F00F);
    check_eq("f00f_nbits", obs_vld,  16);
    check_eq("f00f_run4",  obs_run4, 7);
    check_eq("f00f_done",  obs_done, 1);

    // Short send with slow ticks.
    do_load(16'hA000);
    clr_obs();
    do_start(3, 1'b0);
    for (int i = 0; i < 15; i++) begin
      bus.tick = (i % 3 == 2);
      cycle();
    end
    bus.tick = 1'b0;
    check_eq("slow_bits",  obs_word[2:0], 32'd5);
    check_eq("slow_nbits", obs_vld,  3);
    check_eq("slow_run4",  obs_run4, 0);
    check_eq("slow_done",  obs_done, 1);
    check_eq("slow_hold",  32'(bus.bit_out), 32'd1);

    // Repeat mode then abort together with a tick.
    do_load(16'h8000);
    clr_obs();
    bus.tick = 1'b1;
    do_start(2, 1'b1);
    repeat (5) cycle();
    bus.stop = 1'b1;
    cycle();
    check_eq("rep_busy_after_stop", 32'(bus.busy), 32'd0);
    bus.stop = 1'b0;
    repeat (4) cycle();
    bus.tick = 1'b0;
    bus.rep  = 1'b0;
    check_eq("rep_bits",  obs_word[4:0], 32'h15);
    check_eq("rep_nbits", obs_vld,  5);
    check_eq("rep_done",  obs_done, 0);

    // Zero length is ignored, oversize length clamps to W.
    do_start(0, 1'b0);
    check_eq("len0_busy", 32'(bus.busy), 32'd0);
    do_load(16'hFFFF);
    clr_obs();
    bus.tick = 1'b1;
    do_start(20, 1'b0);
    repeat (20) cycle();
    bus.tick = 1'b0;
    check_eq("clamp_nbits", obs_vld,  16);
    check_eq("clamp_run4",  obs_run4, 13);

    // Load/start while sending are ignored; the next send reuses the old pattern.
    do_load(16'hC3A5);
    clr_obs();
    do_start(16, 1'b0);
    bus.tick = 1'b1;
    repeat (3) cycle();
    bus.pat   = 16'h0000;
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.len   = LW'(4);
    cycle();
    clear_inputs();
    bus.tick = 1'b1;
    repeat (16) cycle();
    bus.tick = 1'b0;
    check_eq("busy_ign_bits", obs_word[15:0], 32'h0000C3A5);
    clr_obs();
    bus.tick = 1'b1;
    do_start(16, 1'b0);
    repeat (18) cycle();
    bus.tick = 1'b0;
    check_eq("busy_ign_next", obs_word[15:0], 32'h0000C3A5);

    // Reset mid-send, asynchronously between clock edges.
    do_load(16'hF00F);
    bus.tick = 1'b1;
    do_start(16, 1'b0);
    repeat (5) cycle();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    repeat (2) cycle();
    #2 rst_n = 1'b1;
    clr_obs();
    repeat (6) cycle();
    bus.tick = 1'b0;
    check_eq("midrst_nbits", obs_vld, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.load  = ($urandom_range(0, 7) == 0);
      bus.pat   = W'($urandom);
      bus.len   = LW'($urandom_range(0, 20));
      bus.rep   = ($urandom_range(0, 3) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 39) == 0);
      bus.tick  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    clear_inputs();
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
